// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for sync_fifo_param.
//   - cnt_width / ptr_width: widths of the occupancy count and of the pointers.
//   - default threshold constants for the almost-full / almost-empty flags.
//   - fifo_params_ok: parameter legality check, evaluated at elaboration.
package fifo_pkg;

    // Default almost_empty threshold.
    localparam int unsigned AE_LEVEL_DEFAULT = 2;
    // Default almost_full threshold sits this many entries below DEPTH.
    localparam int unsigned AF_MARGIN_DEFAULT = 2;

    // Pointer width: one bit per doubling of depth.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Count width: one extra bit so the value DEPTH itself fits.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // True when the parameter set is legal: DEPTH a power of two in 2..256,
    // WIDTH >= 1, AF_LEVEL in 1..DEPTH, AE_LEVEL in 0..DEPTH-1.
    function automatic bit fifo_params_ok(input int width, input int depth,
                                          input int af_level, input int ae_level);
        return (width >= 1) &&
               (depth >= 2) && (depth <= 256) && ((depth & (depth - 1)) == 0) &&
               (af_level >= 1) && (af_level <= depth) &&
               (ae_level >= 0) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping pointer for sync_fifo_param.
// The pointer counts modulo 2**W, so with W = clog2(DEPTH) and a power-of-two
// DEPTH it wraps from DEPTH-1 to 0 with no extra compare.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset (pointer -> 0)
//   clr  - synchronous clear (pointer -> 0), wins over inc
//   inc  - advance the pointer by one
//   ptr  - current pointer value
module fifo_ptr #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with registered read data.
// Optional feature macro: SYNC_FIFO_STICKY_ERR_EN
//   defined   - overflow/underflow are sticky until clr or rst
//   undefined - overflow/underflow pulse for the cycle after each rejected access
// Ports:
//   clk, rst (async active-low), clr (sync clear, highest priority)
//   wr_en, wr_data              - write request and data
//   rd_en                       - read request
//   rd_data, rd_valid           - registered read data and its update strobe
//   full, empty                 - occupancy flags
//   almost_full, almost_empty   - threshold flags
//   count                       - occupancy 0..DEPTH
//   overflow, underflow         - rejected write / rejected read indicators
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 9,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - int'(AF_MARGIN_DEFAULT),
    parameter int AE_LEVEL = int'(AE_LEVEL_DEFAULT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic                          rd_en,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          rd_valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    if (!fifo_params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("sync_fifo_param: illegal parameters WIDTH=%0d DEPTH=%0d AF_LEVEL=%0d AE_LEVEL=%0d",
               WIDTH, DEPTH, AF_LEVEL, AE_LEVEL);
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic rd_acc;
    logic wr_acc;
    logic wr_rej;
    logic rd_rej;
    logic wr_inc;
    logic rd_inc;

    // Reads need stored data (no fall-through); a write into a full FIFO is
    // allowed only when a read frees a slot in the same cycle.
    always_comb begin
        rd_acc = rd_en && (count != '0);
        wr_acc = wr_en && ((count != DEPTH_C) || rd_acc);
        wr_rej = wr_en && !wr_acc;
        rd_rej = rd_en && !rd_acc;
        wr_inc = wr_acc && !clr;
        rd_inc = rd_acc && !clr;
    end

    fifo_ptr #(.W(PW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (wr_acc),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.W(PW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (rd_acc),
        .ptr (rd_ptr)
    );

    // Storage has no reset; contents are unreachable until rewritten.
    always_ff @(posedge clk) begin
        if (wr_inc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (wr_inc && !rd_inc) begin
            count <= count + CW'(1);
        end else if (rd_inc && !wr_inc) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_inc;
            if (rd_inc) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
`ifdef SYNC_FIFO_STICKY_ERR_EN
            overflow  <= overflow  | wr_rej;
            underflow <= underflow | rd_rej;
`else
            overflow  <= wr_rej;
            underflow <= rd_rej;
`endif
        end
    end

    // Flags decode only the registered count, so no input reaches them combinationally.
    always_comb begin
        full         = (count == DEPTH_C);
        empty        = (count == '0);
        almost_full  = (count >= AF_C);
        almost_empty = (count <= AE_C);
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: scoreboard bench for sync_fifo_param (WIDTH=9, DEPTH=8,
// AF_LEVEL=6, AE_LEVEL=2). A queue-based reference model predicts each cycle;
// predictions are queued and a monitor on the falling edge compares them.
module tb_sync_fifo_param;

    localparam int WIDTH = 9;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clr = 1'b0;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full, empty, almost_full, almost_empty;
    logic [3:0]       count;
    logic             overflow, underflow;

    sync_fifo_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cnt;
        bit         ovf;
        bit         unf;
        bit         vld;
        logic [8:0] last;
    } st_t;

    int checks = 0;
    int errors = 0;

    // reference model state
    int         mq[$];
    bit         m_ovf = 0;
    bit         m_unf = 0;
    logic [8:0] m_last = '0;

    st_t        st_q[$];
    logic [8:0] data_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: consume one prediction per cycle, one data entry per rd_valid
    always @(negedge clk) begin
        if (rst && st_q.size() > 0) begin
            st_t s;
            s = st_q.pop_front();
            chk("count", int'(count), s.cnt);
            chk("full", int'(full), int'(s.cnt == DEPTH));
            chk("empty", int'(empty), int'(s.cnt == 0));
            chk("almost_full", int'(almost_full), int'(s.cnt >= AF));
            chk("almost_empty", int'(almost_empty), int'(s.cnt <= AE));
            chk("overflow", int'(overflow), int'(s.ovf));
            chk("underflow", int'(underflow), int'(s.unf));
            chk("rd_valid", int'(rd_valid), int'(s.vld));
            if (rd_valid) begin
                if (data_q.size() == 0) begin
                    chk("rd_data_unexpected", int'(rd_data), -1);
                end else begin
                    chk("rd_data", int'(rd_data), int'(data_q.pop_front()));
                end
            end else begin
                chk("rd_data_hold", int'(rd_data), int'(s.last));
            end
        end
    end

    // one clock of stimulus; called at posedge+1
    task automatic step(input bit w, input logic [8:0] d, input bit r, input bit c);
        bit rd_acc, wr_acc;
        st_t s;
        wr_en = w; wr_data = d; rd_en = r; clr = c;
        rd_acc = r && (mq.size() > 0);
        wr_acc = w && ((mq.size() < DEPTH) || rd_acc);
        s.vld = 0;
        if (c) begin
            mq.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
`ifdef SYNC_FIFO_STICKY_ERR_EN
            m_ovf = m_ovf | (w && !wr_acc);
            m_unf = m_unf | (r && !rd_acc);
`else
            m_ovf = w && !wr_acc;
            m_unf = r && !rd_acc;
`endif
            if (rd_acc) begin
                m_last = 9'(mq.pop_front());
                s.vld = 1;
            end
            if (wr_acc) mq.push_back(int'(d));
        end
        s.cnt = mq.size();
        s.ovf = m_ovf;
        s.unf = m_unf;
        s.last = m_last;
        @(posedge clk);
        st_q.push_back(s);
        if (s.vld) data_q.push_back(m_last);
        #1;
        wr_en = 0; rd_en = 0; clr = 0;
    endtask

    task automatic drain_wait();
        int budget = 20;
        while ((st_q.size() > 0) && (budget > 0)) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (st_q.size() > 0) chk("monitor_timeout", st_q.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_ae"}, int'(almost_empty), 1);
        chk({tag, "_af"}, int'(almost_full), 0);
        chk({tag, "_rd_data"}, int'(rd_data), 0);
        chk({tag, "_rd_valid"}, int'(rd_valid), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
        chk({tag, "_unf"}, int'(underflow), 0);
    endtask

    initial begin
        // reset and idle
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        step(0, '0, 0, 0);
        step(0, '0, 1, 0);          // underflow on empty
        step(0, '0, 0, 0);

        // fill to full, then one dropped write
        for (int i = 1; i <= 9; i++) step(1, 9'(9'h100 + i), 0, 0);
        step(0, '0, 0, 0);

        // read everything back
        for (int i = 0; i < 8; i++) step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        // wrap: write 5 / read 5, four rounds
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 5; i++) step(1, 9'($urandom_range(0, 511)), 0, 0);
            for (int i = 0; i < 5; i++) step(0, '0, 1, 0);
        end

        // full with simultaneous write and read, 0x1AA comes out last
        for (int i = 0; i < 8; i++) step(1, 9'(9'h010 + i), 0, 0);
        step(1, 9'h1AA, 1, 0);
        for (int i = 0; i < 8; i++) step(0, '0, 1, 0);

        // empty: simultaneous write/read, then clr beats wr_en
        step(1, 9'h055, 1, 0);
        step(1, 9'h066, 0, 1);
        step(0, '0, 0, 0);

        // error persistence: overflow, then idle cycles, then clr
        for (int i = 0; i < 9; i++) step(1, 9'(i), 0, 0);
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        step(0, '0, 0, 1);
        step(0, '0, 0, 0);

        // randomised traffic with occasional clears
        for (int i = 0; i < 600; i++) begin
            int wb, rb;
            wb = (i / 100) % 3;
            wb = (wb == 0) ? 70 : (wb == 1) ? 30 : 50;
            rb = 100 - wb;
            step(($urandom_range(0, 99) < wb), 9'($urandom_range(0, 511)),
                 ($urandom_range(0, 99) < rb), ($urandom_range(0, 59) == 0));
        end

        // asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) step(1, 9'($urandom_range(0, 511)), 0, 0);
        drain_wait();
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        check_reset_values("midreset");
        mq.delete(); m_ovf = 0; m_unf = 0; m_last = '0;
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        step(0, '0, 1, 0);          // nothing survived: underflow
        step(1, 9'h0AB, 0, 0);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        drain_wait();
        @(negedge clk); #1;
        if (data_q.size() != 0) chk("data_q_leftover", data_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
